// File: rtl/spi_mul_pkg.sv
// Shared definitions for the SPI-attached sequential multiplier.
//   - Opcode constants (4-bit encodings) for MUL, MULHU and MULH.
//   - state_t: protocol state machine encoding used by spi_seq_multiplier.
package spi_mul_pkg;

  localparam logic [3:0] OP_MUL   = 4'b1001; // low half of the product
  localparam logic [3:0] OP_MULHU = 4'b1010; // high half, unsigned x unsigned
  localparam logic [3:0] OP_MULH  = 4'b1011; // high half, signed x signed

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RX_OP   = 3'd1,
    RX_A    = 3'd2,
    RX_B    = 3'd3,
    EXECUTE = 3'd4,
    SEND    = 3'd5
  } state_t;

endpackage

// File: rtl/spi_bus_if.sv
// Four-wire SPI bus bundle.
//   sclk, nss (active-low select), mosi : driven by the master
//   miso                                : driven by the slave
interface spi_bus_if;
  logic sclk;
  logic nss;
  logic mosi;
  logic miso;

  modport SLAVE  (input sclk, input nss, input mosi, output miso);
  modport MASTER (output sclk, output nss, output mosi, input miso);
endinterface

// File: rtl/seq_mul_core.sv
// Iterative shift-add multiplier, one multiplier bit per clock.
//   clock, reset : clock and asynchronous active-high reset
//   start_i      : load operands and begin (ignored while busy)
//   signed_i     : treat both operands as two's complement
//   abort_i      : stop iterating immediately, no done pulse
//   a_i, b_i     : multiplicand / multiplier
//   busy_o       : high for exactly DATA_W clocks per operation
//   done_o       : one-clock pulse on the clock after the last iteration
//   product_o    : full 2*DATA_W-bit product
module seq_mul_core #(
  parameter int DATA_W = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic                  signed_i,
  input  logic                  abort_i,
  input  logic [DATA_W-1:0]     a_i,
  input  logic [DATA_W-1:0]     b_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [2*DATA_W-1:0]   product_o
);

  localparam int CNT_W = $clog2(DATA_W);

  logic [2*DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0]   mplier_q, mplier_d;
  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                signed_q, signed_d;

  logic                last_iter;
  logic [2*DATA_W-1:0] partial;

  assign last_iter = (cnt_q == CNT_W'(DATA_W - 1));
  assign partial   = mplier_q[0] ? mcand_q : '0;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    signed_d = signed_q;

    if (abort_i) begin
      busy_d = 1'b0;
    end else if (start_i && !busy_q) begin
      // Sign-extending the multiplicand to full width makes every partial
      // product correct modulo 2^(2*DATA_W).
      mcand_d  = signed_i ? {{DATA_W{a_i[DATA_W-1]}}, a_i} : {{DATA_W{1'b0}}, a_i};
      mplier_d = b_i;
      acc_d    = '0;
      cnt_d    = '0;
      busy_d   = 1'b1;
      signed_d = signed_i;
    end else if (busy_q) begin
      // In signed mode the multiplier MSB carries weight -2^(DATA_W-1),
      // so its partial product is subtracted.
      if (signed_q && last_iter) begin
        acc_d = acc_q - partial;
      end else begin
        acc_d = acc_q + partial;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
      if (last_iter) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      signed_q <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      signed_q <= signed_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign product_o = acc_q;

endmodule

// File: rtl/spi_seq_multiplier.sv
// SPI slave front end for the sequential multiplier.
// Frame from master (MSB-first): opcode (OP_W bits), A (DATA_W), B (DATA_W).
// The master then polls miso (0 while computing) until the 1 marker shows,
// and clocks out the marker plus DATA_W result bits.
//   clock, reset : clock and asynchronous active-high reset
//   spi_if       : SPI slave port (sclk, nss, mosi in; miso out)
//   busy         : multiply engine iterating
//   op_done      : one-clock pulse when a result frame is loaded
//   illegal_op   : sticky flag for unsupported opcodes
module spi_seq_multiplier
  import spi_mul_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input  logic      clock,
  input  logic      reset,
  spi_bus_if.SLAVE  spi_if,
  output logic      busy,
  output logic      op_done,
  output logic      illegal_op
);

  localparam int CNT_MAX = (DATA_W > OP_W) ? DATA_W : OP_W;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return (op == OP_W'(OP_MUL)) || (op == OP_W'(OP_MULHU)) || (op == OP_W'(OP_MULH));
  endfunction

  // Synchronisers; the third sclk flop delays by one clock for edge detect.
  logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
  logic nss_s1_q, nss_s2_q;
  logic mosi_s1_q, mosi_s2_q;
  logic sclk_rise;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W:0]     shift_q, shift_d;
  logic [OP_W-1:0]     opcode_q, opcode_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic                illegal_q, illegal_d;
  logic                op_done_q, op_done_d;

  logic [DATA_W:0]     rx_shift;
  logic                core_start, core_abort, core_busy, core_done;
  logic [2*DATA_W-1:0] core_product;

  assign sclk_rise = sclk_s2_q & ~sclk_s3_q;
  assign rx_shift  = {shift_q[DATA_W-1:0], mosi_s2_q};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sclk_s1_q <= 1'b0;
      sclk_s2_q <= 1'b0;
      sclk_s3_q <= 1'b0;
      nss_s1_q  <= 1'b0;
      nss_s2_q  <= 1'b0;
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
    end else begin
      sclk_s1_q <= spi_if.sclk;
      sclk_s2_q <= sclk_s1_q;
      sclk_s3_q <= sclk_s2_q;
      nss_s1_q  <= spi_if.nss;
      nss_s2_q  <= nss_s1_q;
      mosi_s1_q <= spi_if.mosi;
      mosi_s2_q <= mosi_s1_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    opcode_d    = opcode_q;
    a_d         = a_q;
    b_d         = b_q;
    illegal_d   = illegal_q;
    op_done_d   = 1'b0;
    core_start  = 1'b0;
    core_abort  = 1'b0;

    if (nss_s2_q && (state_q != IDLE)) begin
      // Master deselected mid-transaction: drop everything, keep flags.
      state_d    = IDLE;
      core_abort = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d   = '0;
          shift_d = '0;
          if (!nss_s2_q) state_d = RX_OP;
        end
        RX_OP: begin
          if (sclk_rise) begin
            shift_d = rx_shift;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(OP_W - 1)) begin
              opcode_d = rx_shift[OP_W-1:0];
              if (op_legal(rx_shift[OP_W-1:0])) illegal_d = 1'b0;
              cnt_d    = '0;
              shift_d  = '0;
              state_d  = RX_A;
            end
          end
        end
        RX_A: begin
          if (sclk_rise) begin
            shift_d = rx_shift;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
              a_d     = rx_shift[DATA_W-1:0];
              cnt_d   = '0;
              shift_d = '0;
              state_d = RX_B;
            end
          end
        end
        RX_B: begin
          if (sclk_rise) begin
            shift_d = rx_shift;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
              b_d        = rx_shift[DATA_W-1:0];
              cnt_d      = '0;
              shift_d    = '0;
              state_d    = EXECUTE;
              core_start = op_legal(opcode_q);
            end
          end
        end
        EXECUTE: begin
          // sclk edges are ignored here; miso stays 0 until SEND.
          if (!op_legal(opcode_q)) begin
            shift_d   = {1'b1, {DATA_W{1'b0}}};
            illegal_d = 1'b1;
            op_done_d = 1'b1;
            cnt_d     = '0;
            state_d   = SEND;
          end else if (core_done) begin
            shift_d   = (opcode_q == OP_W'(OP_MUL)) ?
                        {1'b1, core_product[DATA_W-1:0]} :
                        {1'b1, core_product[2*DATA_W-1:DATA_W]};
            op_done_d = 1'b1;
            cnt_d     = '0;
            state_d   = SEND;
          end
        end
        SEND: begin
          if (sclk_rise) begin
            shift_d = shift_q << 1;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DATA_W)) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      opcode_q  <= '0;
      a_q       <= '0;
      b_q       <= '0;
      illegal_q <= 1'b0;
      op_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      opcode_q  <= opcode_d;
      a_q       <= a_d;
      b_q       <= b_d;
      illegal_q <= illegal_d;
      op_done_q <= op_done_d;
    end
  end

  // B is handed to the engine straight from the receive shifter so the
  // engine starts on the same edge that enters EXECUTE.
  seq_mul_core #(
    .DATA_W (DATA_W)
  ) u_core (
    .clock     (clock),
    .reset     (reset),
    .start_i   (core_start),
    .signed_i  (opcode_q == OP_W'(OP_MULH)),
    .abort_i   (core_abort),
    .a_i       (a_q),
    .b_i       (rx_shift[DATA_W-1:0]),
    .busy_o    (core_busy),
    .done_o    (core_done),
    .product_o (core_product)
  );

  assign spi_if.miso = (state_q == SEND) ? shift_q[DATA_W] : 1'b0;
  assign busy        = core_busy;
  assign op_done     = op_done_q;
  assign illegal_op  = illegal_q;

endmodule

// File: doc/spi_seq_multiplier.md
SPI_SEQ_MULTIPLIER -- requirements
Module: spi_seq_multiplier

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width in bits (legal 8..64, even).
REQ-002 SHALL have parameter OP_W, default 4, opcode field width in bits.
REQ-003 SHALL have port clock  input  1  system clock; all state on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port spi_if  modport SLAVE  --  sclk, nss (active-low), mosi inputs; miso output.
REQ-006 SHALL have port busy  output  1  high while the multiply engine is iterating.
REQ-007 SHALL have port op_done  output  1  one-clock pulse when a result is loaded for transmission.
REQ-008 SHALL have port illegal_op  output  1  sticky; set by an unsupported opcode.

Function
REQ-009 SHALL pass sclk, nss and mosi through 2-flop synchronisers; clock SHALL be >= 8x sclk.
REQ-010 SHALL detect sclk rising edges on the synchronised signal, one clock after the second flop.
REQ-011 SHALL implement states IDLE, RX_OP, RX_A, RX_B, EXECUTE, SEND.
REQ-012 IDLE -> RX_OP when synchronised nss is low; counter and shift register SHALL be cleared.
REQ-013 RX_OP SHALL shift OP_W mosi bits MSB-first, then go to RX_A.
REQ-014 RX_A and RX_B SHALL each shift DATA_W bits MSB-first; RX_B -> EXECUTE on the last bit.
REQ-015 Supported opcodes: 4'b1001 MUL (low DATA_W bits), 4'b1010 MULHU (high, unsigned x unsigned), 4'b1011 MULH (high, signed x signed).
REQ-016 Result SHALL equal the exact 2*DATA_W-bit product of the operands, extended per opcode; MUL low half SHALL be sign-independent.
REQ-017 EXECUTE SHALL use an iterative shift-add engine taking exactly DATA_W clocks; busy SHALL be high for exactly those clocks.
REQ-018 On the clock after the last iteration, the {1'b1, result} DATA_W+1-bit frame SHALL be loaded; op_done SHALL pulse; state -> SEND.
REQ-019 An unsupported opcode SHALL skip iteration, load {1'b1, zero}, set illegal_op, and pulse op_done after one EXECUTE clock.
REQ-020 miso SHALL be 0 in every state except SEND; sclk edges during EXECUTE SHALL be ignored (master polls for the 1 marker).
REQ-021 In SEND, miso SHALL equal the frame MSB; each sclk rising edge SHALL shift left; after DATA_W+1 edges -> IDLE.
REQ-022 nss high in any state other than IDLE SHALL abort to IDLE on the next clock; busy SHALL drop, with no op_done and no output change.
REQ-023 illegal_op SHALL clear only on reset or on the start of a transaction whose opcode is legal.
REQ-024 Any state encoding that is not a defined state SHALL return to IDLE.

Reset
REQ-025 Reset SHALL force IDLE; operands, opcode, counters, shift and product registers SHALL be zero.
REQ-026 Under reset: miso=0, busy=0, op_done=0, illegal_op=0, synchroniser flops cleared; effective mid-operation with no delay.

Structure
REQ-027 Opcode constants and the state_t enum SHALL live in shared package spi_mul_pkg.
REQ-028 The iterative engine SHALL be sub-module seq_mul_core (start, signed-mode and operand inputs; busy, done and 2*DATA_W product outputs).
REQ-029 Counter widths SHALL be derived with $clog2 from DATA_W and OP_W.

Verification
REQ-030 DATA_W=32, MUL 7 x 6 -> after polling, miso returns marker 1 then 0x0000002A; op_done pulses once.
REQ-031 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MUL on the same operands -> 0x00000001.
REQ-032 MULH 0xFFFFFFFF x 0x00000002 -> 0xFFFFFFFF; MULHU on the same operands -> 0x00000001.
REQ-033 Opcode 4'b0011 -> marker then 0x00000000; illegal_op=1; the next legal MUL clears it.
REQ-034 nss raised after 10 bits of A -> IDLE, no op_done; the next full 3 x 5 MUL transaction returns 0x0000000F.
REQ-035 Reset asserted at EXECUTE cycle 12 -> all outputs 0 immediately, state IDLE; busy high for exactly 32 clocks when not disturbed.
